// File: rtl/unidad_load_store_if.sv
// Request/response bundle between the EX/MEM stage, the load/store unit and the data memory.
// The slave modport is the unit's view; the master modport drives requests and memory data.
interface unidad_load_store_if #(
  parameter int unsigned NBITS = 32
);
  logic             i_Valid;
  logic             i_MemRead;
  logic             i_MemWrite;
  logic [1:0]       i_Tamano;
  logic             i_Unsigned;
  logic [NBITS-1:0] i_Direccion;
  logic [NBITS-1:0] i_DatoEscribir;
  logic [NBITS-1:0] i_MemDatoLeido;
  logic [NBITS-1:0] o_MemDireccion;
  logic [NBITS-1:0] o_MemDato;
  logic             o_MemRead;
  logic             o_MemWrite;
  logic [NBITS-1:0] o_DatoLoad;
  logic             o_Listo;
  logic             o_Error;
  logic             o_Stall;

  modport slave (
    input  i_Valid, i_MemRead, i_MemWrite, i_Tamano, i_Unsigned, i_Direccion,
           i_DatoEscribir, i_MemDatoLeido,
    output o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite, o_DatoLoad, o_Listo,
           o_Error, o_Stall
  );

  modport master (
    output i_Valid, i_MemRead, i_MemWrite, i_Tamano, i_Unsigned, i_Direccion,
           i_DatoEscribir, i_MemDatoLeido,
    input  o_MemDireccion, o_MemDato, o_MemRead, o_MemWrite, o_DatoLoad, o_Listo,
           o_Error, o_Stall
  );
endinterface

// File: rtl/unidad_load_store.sv
// Load/store alignment unit: turns byte-addressed loads/stores into word accesses,
// using read-modify-write for sub-word stores and lane extraction/extension for loads.
module unidad_load_store #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned CELDAS = 16
) (
  input logic                i_clk,
  input logic                i_reset,
  unidad_load_store_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLeer, StEspera, StEscribir, StListo} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [NBITS-1:0] load_q, load_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             store_q, store_d;
  logic             err_q, err_d;

  logic             req;
  logic             req_err;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [NBITS-1:0] lane_val;
  logic [NBITS-1:0] merged;

  always_comb begin
    req     = bus.i_Valid & (bus.i_MemRead | bus.i_MemWrite);
    req_err = (bus.i_Tamano == 2'b10) ||
              ((bus.i_Tamano == 2'b01) && bus.i_Direccion[0]) ||
              ((bus.i_Tamano == 2'b11) && (bus.i_Direccion[1:0] != 2'b00)) ||
              (bus.i_MemRead && bus.i_MemWrite) ||
              ({2'b00, bus.i_Direccion[NBITS-1:2]} >= NBITS'(CELDAS));
  end

  // Lane extraction for loads and lane replacement for read-modify-write stores.
  always_comb begin
    byte_sel = bus.i_MemDatoLeido[{addr_q[1:0], 3'b000} +: 8];
    half_sel = bus.i_MemDatoLeido[{addr_q[1], 4'b0000} +: 16];
    merged   = bus.i_MemDatoLeido;
    case (size_q)
      2'b00: begin
        lane_val = uns_q ? {{(NBITS-8){1'b0}}, byte_sel}
                         : {{(NBITS-8){byte_sel[7]}}, byte_sel};
        merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      end
      2'b01: begin
        lane_val = uns_q ? {{(NBITS-16){1'b0}}, half_sel}
                         : {{(NBITS-16){half_sel[15]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      end
      default: lane_val = bus.i_MemDatoLeido;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    load_d  = load_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = bus.i_Direccion;
          data_d  = bus.i_DatoEscribir;
          size_d  = bus.i_Tamano;
          uns_d   = bus.i_Unsigned;
          store_d = bus.i_MemWrite;
          err_d   = req_err;
          if (req_err) begin
            state_d = StListo;
          end else if (!bus.i_MemRead && (bus.i_Tamano == 2'b11)) begin
            state_d = StEscribir;
          end else begin
            state_d = StLeer;
          end
        end
      end
      StLeer:   state_d = StEspera;
      StEspera: begin
        if (store_q) begin
          data_d  = merged;
          state_d = StEscribir;
        end else begin
          load_d  = lane_val;
          state_d = StListo;
        end
      end
      StEscribir: state_d = StListo;
      StListo:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.o_MemDireccion = {2'b00, addr_q[NBITS-1:2]};
    bus.o_MemDato      = data_q;
    bus.o_MemRead      = (state_q == StLeer);
    bus.o_MemWrite     = (state_q == StEscribir);
    bus.o_DatoLoad     = load_q;
    bus.o_Listo        = (state_q == StListo);
    bus.o_Error        = (state_q == StListo) && err_q;
    // Stall drops in LISTO so the pipeline advances on the edge that leaves it.
    bus.o_Stall        = (state_q == StLeer) || (state_q == StEspera) ||
                         (state_q == StEscribir) || ((state_q == StIdle) && req);
  end

endmodule
